// File: rtl/poly_cmd_seq.sv
// ---------------------------------------------------------------------------
// poly_cmd_seq
//
// Command sequencer for a polynomial engine. Commands are queued in a small
// FIFO and issued one at a time: a command is popped in IDLE, a one-cycle
// start pulse launches it, the sequencer waits in BUSY for the engine's
// finish pulse, then pulses done and bumps a wrapping completion counter.
//
// Optional feature (compile-time macro CMD_TIMEOUT_EN):
//   When defined, a watchdog counts BUSY cycles and abandons a command that
//   has not finished after TIMEOUT_CYCLES cycles, pulsing timeout instead of
//   done. When undefined, timeout is tied low and BUSY waits indefinitely.
//
// Parameters:
//   FIFO_DEPTH      command FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES  watchdog limit in BUSY cycles (used with CMD_TIMEOUT_EN)
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  FIFO can accept a command
//   cmd_data   in   [3:2] opcode, [1] mode, [0] offset
//   opcode     out  opcode of the command in flight
//   mode       out  mode of the command in flight
//   offset     out  offset of the command in flight
//   start      out  one-cycle launch pulse to the engine
//   finish     in   one-cycle completion pulse from the engine
//   done       out  one-cycle pulse per completed command
//   timeout    out  one-cycle watchdog pulse
//   busy       out  sequencer not in IDLE
//   cmd_level  out  FIFO occupancy
//   done_cnt   out  completed-command count, wraps at 16 bits
// ---------------------------------------------------------------------------
module poly_cmd_seq #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_data,
    output logic [1:0]                    opcode,
    output logic                          mode,
    output logic                          offset,
    output logic                          start,
    input  logic                          finish,
    output logic                          done,
    output logic                          timeout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_level,
    output logic [15:0]                   done_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    // Reject configurations the pointer-wrap logic cannot handle.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("poly_cmd_seq: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [3:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic [1:0]      r_opcode;
    logic            r_mode;
    logic            r_offset;
    logic            r_start;
    logic [15:0]     r_done_cnt;

    logic            w_push;
    logic            w_pop;
    logic [3:0]      w_head;

`ifdef CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0]   r_wd_cnt;
    logic            r_timeout;
    logic            w_wd_hit;
`endif

    // Ready comes from the registered occupancy only, so a pop on the same
    // edge never opens a slot combinationally.
    assign cmd_ready = (r_level < DEPTH_L);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_head    = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Next-state / decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
`ifdef CMD_TIMEOUT_EN
        w_wd_hit = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop  = 1'b1;
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next = S_BUSY;
            end
            S_BUSY: begin
                // finish has priority over a watchdog expiry in the same cycle
                if (finish) begin
                    w_next = S_DONE;
                end
`ifdef CMD_TIMEOUT_EN
                else if (r_wd_cnt == WD_LIMIT) begin
                    w_wd_hit = 1'b1;
                    w_next   = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage (data only, not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_data;
        end
    end

    // ------------------------------------------------------------------
    // State, pointers, occupancy and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_opcode   <= '0;
            r_mode     <= 1'b0;
            r_offset   <= 1'b0;
            r_start    <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            r_state <= w_next;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_opcode <= w_head[3:2];
                r_mode   <= w_head[1];
                r_offset <= w_head[0];
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            // The launch pulse is registered on leaving LAUNCH, which gives
            // the two-edge pop-to-start latency seen at the engine.
            r_start <= (r_state == S_LAUNCH);

            if (r_state == S_DONE) begin
                r_done_cnt <= r_done_cnt + 16'd1;
            end
        end
    end

`ifdef CMD_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Watchdog: cleared in LAUNCH, counts every BUSY cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_wd_cnt <= '0;
            end else if (r_state == S_BUSY) begin
                r_wd_cnt <= r_wd_cnt + CW'(1);
            end
            r_timeout <= w_wd_hit;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign opcode    = r_opcode;
    assign mode      = r_mode;
    assign offset    = r_offset;
    assign start     = r_start;
    assign done      = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign cmd_level = r_level;
    assign done_cnt  = r_done_cnt;

endmodule

// File: doc/poly_cmd_seq.md
POLY_CMD_SEQ -- requirements
Module: poly_cmd_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command FIFO entries, power of two, at least 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit in BUSY cycles.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  FIFO can accept a command.
REQ-008 cmd_data  input  4  [3:2] opcode, [1] mode, [0] offset.
REQ-009 opcode  output  2  opcode to the polynomial engine.
REQ-010 mode  output  1  mode to the polynomial engine.
REQ-011 offset  output  1  offset to the polynomial engine.
REQ-012 start  output  1  one-cycle launch pulse to the engine.
REQ-013 finish  input  1  one-cycle completion pulse from the engine.
REQ-014 done  output  1  one-cycle pulse per completed command.
REQ-015 timeout  output  1  one-cycle watchdog pulse.
REQ-016 busy  output  1  high when the sequencer is not in IDLE.
REQ-017 cmd_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-018 done_cnt  output  16  completed-command count, wraps 0xFFFF->0.

Function
REQ-019 SHALL push cmd_data on a rising edge with cmd_valid and cmd_ready both high; cmd_ready = (cmd_level < FIFO_DEPTH), decoded from registered occupancy only.
REQ-020 SHALL leave cmd_valid with cmd_ready low with no effect (no push, no loss of stored entries).
REQ-021 FSM states SHALL be IDLE, LAUNCH, BUSY, DONE.
REQ-022 IDLE with cmd_level>0: pop the head, register opcode/mode/offset, go to LAUNCH; IDLE with empty FIFO: stay.
REQ-023 LAUNCH: start=1 for exactly one cycle, then BUSY.
REQ-024 BUSY: on finish=1 go to DONE; otherwise stay.
REQ-025 DONE: done=1 for one cycle, increment done_cnt, then IDLE.
REQ-026 finish SHALL be ignored in IDLE, LAUNCH and DONE.
REQ-027 opcode/mode/offset SHALL change only on a pop edge and hold through LAUNCH, BUSY and DONE.
REQ-028 With the FIFO empty in IDLE, a command accepted at edge N SHALL produce start high in the cycle following edge N+2.
REQ-029 Push and pop on the same edge SHALL leave cmd_level unchanged; FIFO order SHALL be strictly first-in first-out with pointer wrap at FIFO_DEPTH.
REQ-030 Commands SHALL be launched back to back with no intermediate gap beyond DONE->IDLE->LAUNCH (minimum 3 cycles between finish and the next start).

Reset
REQ-031 rst SHALL force IDLE, empty the FIFO and clear the pointers; outputs SHALL be cmd_ready=1, opcode=0, mode=0, offset=0, start=0, done=0, timeout=0, busy=0, cmd_level=0, done_cnt=0.
REQ-032 rst asserted mid-operation SHALL abandon the in-flight command with no done or timeout pulse; a finish arriving after release in IDLE SHALL be ignored.

Configuration
REQ-033 With CMD_TIMEOUT_EN defined: a counter SHALL clear in LAUNCH and increment each BUSY cycle; BUSY with count == TIMEOUT_CYCLES-1 and finish=0 SHALL pulse timeout, skip DONE, leave done_cnt unchanged and go to IDLE; if finish coincides with the limit, finish wins.
REQ-034 Without CMD_TIMEOUT_EN: timeout SHALL be tied 0, no counter SHALL exist, and BUSY SHALL wait indefinitely.

Verification
REQ-035 Reset, push cmd_data=4'b1011, finish 20 cycles after start -> opcode=2, mode=1, offset=1, one start pulse, one done pulse, done_cnt=1.
REQ-036 Push 5 commands back to back with FIFO_DEPTH=4 while BUSY -> cmd_ready low after the 4th, 5th held until a pop, all 5 launched in order.
REQ-037 finish pulses in IDLE and in the LAUNCH cycle -> no done, done_cnt unchanged.
REQ-038 CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, no finish -> timeout pulse 16 cycles after entering BUSY, then IDLE, done_cnt unchanged; second run with finish on cycle 16 -> done, no timeout.
REQ-039 rst pulsed during BUSY with 2 entries queued -> all outputs at reset values, cmd_level=0, no start after release.
REQ-040 Preload done_cnt to 0xFFFF via 65535 completions (or forced) plus one more -> done_cnt=0.
